// File: rtl/calc_pkg.sv
// calc_pkg: shared opcodes, FSM states and default width for the calculator datapath
package calc_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [2:0] {
    OP_ADD       = 3'b000,
    OP_SUB       = 3'b001,
    OP_ADD_PREV  = 3'b010,
    OP_SUB_PREV  = 3'b011,
    OP_MULT      = 3'b100,
    OP_DIV       = 3'b101,
    OP_MULT_PREV = 3'b110,
    OP_DIV_PREV  = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/calc_shift_add_mul.sv
// calc_shift_add_mul: sign-magnitude shift-add multiplier, one partial product per cycle, WIDTH cycles
// Ports: clk, rst_n (async low), clear (abort), start (load a/b), a, b (signed);
//        product (low WIDTH bits, valid with done), done (final iteration cycle), ovf (product not signed-WIDTH representable)
module calc_shift_add_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             ovf
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] LIM = PW'(1) << (WIDTH - 1);
  logic             r_busy, r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand, r_acc, w_acc_next;
  logic [WIDTH-1:0] r_mplier, w_abs_a, w_abs_b, w_lo;
  assign w_abs_a    = a[WIDTH-1] ? -a : a;
  assign w_abs_b    = b[WIDTH-1] ? -b : b;
  // done and product come from the last partial sum combinationally so the top sees them on the final iteration edge
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_lo       = w_acc_next[WIDTH-1:0];
  assign product    = r_neg ? -w_lo : w_lo;
  assign done       = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
  // a negative result may reach magnitude 2^(W-1); a positive one only 2^(W-1)-1
  assign ovf        = w_acc_next > (r_neg ? LIM : LIM - PW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (clear) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      r_cnt    <= '0;
      r_mcand  <= PW'(w_abs_a);
      r_mplier <= w_abs_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      r_busy   <= r_cnt != CNT_W'(WIDTH - 1);
    end
endmodule

// File: rtl/calc_accumulator_datapath.sv
// calc_accumulator_datapath: add/sub/multiply execution stage with previous-result register
// Ports: clk, rst_n (async low), clear (sync abort + zero prev/flags);
//        in_valid/in_ready handshake with operand_a, operand_b, signControl, storePrevControl, memControl, op_in;
//        out_valid (one-cycle pulse), result, overflow, err, prev_value
module calc_accumulator_datapath
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             signControl,
  input  logic             storePrevControl,
  input  logic             memControl,
  input  logic             op_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             err,
  output logic [WIDTH-1:0] prev_value
);
  state_t           r_state, w_next;
  opcode_t          w_opc;
  logic             w_accept, w_mul_op, w_div_op, w_mem_err, w_add_ovf;
  logic             w_mul_done, w_mul_ovf, w_mul_start;
  logic             r_prev_valid, r_ovf, r_err, r_mul_err;
  logic [WIDTH-1:0] w_opa, w_opb, w_sum, w_mul_prod, r_result, r_prev;
  assign w_opc       = opcode_t'({op_in, storePrevControl, signControl});
  assign w_mul_op    = w_opc inside {OP_MULT, OP_MULT_PREV};
  assign w_div_op    = w_opc inside {OP_DIV, OP_DIV_PREV};
  assign w_accept    = in_valid & in_ready;
  assign w_mul_start = w_accept & w_mul_op;
  assign w_mem_err   = memControl & ~r_prev_valid;
  assign w_opa       = storePrevControl ? r_prev : operand_a;
  assign w_opb       = signControl ? ~operand_b : operand_b;
  assign w_sum       = w_opa + w_opb + WIDTH'(signControl);
  assign w_add_ovf   = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
  calc_shift_add_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .start   (w_mul_start),
    .a       (w_opa),
    .b       (operand_b),
    .product (w_mul_prod),
    .done    (w_mul_done),
    .ovf     (w_mul_ovf)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (clear) w_next = S_IDLE;
    else if (r_state == S_IDLE && w_accept) w_next = w_mul_op ? S_MUL : S_DONE;
    else if (r_state == S_MUL && w_mul_done) w_next = S_DONE;
    else if (r_state == S_DONE) w_next = S_IDLE;
  end
  always_comb begin
    in_ready  = rst_n & (r_state == S_IDLE) & ~clear;
    out_valid = r_state == S_DONE;
  end
  // results and prev are written on the edge entering DONE so they are visible with out_valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_result     <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_mul_err    <= 1'b0;
    end else if (clear) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_mul_err    <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_err <= w_mem_err;
    end else if (w_accept) begin
      r_result <= w_div_op ? '0 : w_sum;
      r_ovf    <= ~w_div_op & w_add_ovf;
      r_err    <= w_div_op | w_mem_err;
      if (!(w_div_op | w_mem_err)) begin
        r_prev       <= w_sum;
        r_prev_valid <= 1'b1;
      end
    end else if (r_state == S_MUL && w_mul_done) begin
      r_result <= w_mul_prod;
      r_ovf    <= w_mul_ovf;
      r_err    <= r_mul_err;
      if (!r_mul_err) begin
        r_prev       <= w_mul_prod;
        r_prev_valid <= 1'b1;
      end
    end
  assign result     = r_result;
  assign overflow   = r_ovf;
  assign err        = r_err;
  assign prev_value = r_prev;
endmodule

// File: tb/tb_calc_accumulator_datapath.sv
// tb_calc_accumulator_datapath: directed and random checks against an arithmetic reference model
module tb_calc_accumulator_datapath;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic sc = 1'b0, spc = 1'b0, mc = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, overflow, err;
  logic [W-1:0] result, prev_value;
  int n_chk = 0, n_pass = 0;
  logic [W-1:0] m_prev = '0;
  logic m_pv = 1'b0;
  calc_accumulator_datapath #(.WIDTH(W), .CNT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .operand_a        (a),
    .operand_b        (b),
    .signControl      (sc),
    .storePrevControl (spc),
    .memControl       (mc),
    .op_in            (op),
    .out_valid        (out_valid),
    .result           (result),
    .overflow         (overflow),
    .err              (err),
    .prev_value       (prev_value)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic s, input logic st, input logic m, input logic o,
                        input logic [W-1:0] xa, input logic [W-1:0] xb);
    int lat, av, bv, full;
    logic [W-1:0] er;
    logic eo, ee, is_mul, is_div;
    is_mul = o & ~s;
    is_div = o & s;
    sc = s; spc = st; mc = m; op = o; a = xa; b = xb; in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 1);
    step;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    {sc, spc, mc, op} = 4'($urandom);
    av = st ? int'($signed(m_prev)) : int'($signed(xa));
    bv = $signed(xb);
    full = is_mul ? av * bv : (s ? av - bv : av + bv);
    er = is_div ? '0 : full[W-1:0];
    eo = full < -128 || full > 127;
    ee = is_div | (m & ~m_pv);
    if (!ee) begin
      m_prev = er;
      m_pv = 1'b1;
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (is_mul) chk("busy_not_ready", {31'd0, in_ready}, 0);
      step;
      lat++;
    end
    chk("latency", lat, is_mul ? 9 : 1);
    chk("result", {24'd0, result}, {24'd0, er});
    if (!is_div) chk("overflow", {31'd0, overflow}, {31'd0, eo});
    chk("err", {31'd0, err}, {31'd0, ee});
    step;
    chk("pulse_one_cycle", {31'd0, out_valid}, 0);
    chk("prev_value", {24'd0, prev_value}, {24'd0, m_prev});
  endtask
  task automatic start_mul(input logic [W-1:0] xa, input logic [W-1:0] xb);
    sc = 1'b0; spc = 1'b0; mc = 1'b0; op = 1'b1; a = xa; b = xb; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
  endtask
  initial begin
    logic seen;
    #1;
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_prev", {24'd0, prev_value}, 0);
    chk("rst_flags", {29'd0, out_valid, overflow, err}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    step;
    rst_n = 1'b1;
    step;
    run_op(0, 1, 1, 0, 8'h00, 8'd4);
    run_op(1, 0, 0, 1, 8'd3, 8'd5);
    run_op(0, 0, 0, 0, 8'd5, 8'd3);
    run_op(1, 1, 1, 0, 8'h00, 8'd10);
    run_op(0, 0, 0, 0, 8'd100, 8'd100);
    run_op(1, 0, 0, 0, 8'h80, 8'd1);
    run_op(0, 0, 0, 1, 8'hF9, 8'd9);
    run_op(0, 0, 0, 1, 8'd16, 8'd16);
    run_op(0, 0, 0, 1, 8'h80, 8'd1);
    run_op(0, 1, 1, 1, 8'h00, 8'hFF);
    start_mul(8'd7, 8'd7);
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", {31'd0, in_ready}, 0);
    step;
    clear = 1'b0;
    #1;
    chk("clear_in_ready", {31'd0, in_ready}, 1);
    chk("clear_prev", {24'd0, prev_value}, 0);
    chk("clear_flags", {30'd0, overflow, err}, 0);
    m_prev = '0;
    m_pv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      step;
    end
    chk("clear_no_out_valid", {31'd0, seen}, 0);
    run_op(0, 1, 1, 0, 8'h00, 8'd4);
    run_op(0, 0, 0, 1, 8'd11, 8'd3);
    start_mul(8'd9, 8'd9);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", {24'd0, result}, 0);
    chk("midrst_prev", {24'd0, prev_value}, 0);
    chk("midrst_flags", {28'd0, out_valid, overflow, err, in_ready}, 0);
    m_prev = '0;
    m_pv = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    run_op(0, 1, 1, 0, 8'h00, 8'd7);
    for (int i = 0; i < 80; i++) begin
      logic o, s;
      o = $urandom_range(0, 2) == 0;
      s = o ? ($urandom_range(0, 7) == 0) : 1'($urandom);
      run_op(s, 1'($urandom), ($urandom_range(0, 3) == 0), o, W'($urandom), W'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
